// File: rtl/acs_stage_param_if.sv
// acs_stage_param_if: control, table-load and metric-stream signals of the ACS stage
interface acs_stage_param_if #(
   parameter int DATA_W   = 18,
   parameter int METRIC_W = 18,
   parameter int STATES   = 16,
   parameter int LANES    = 2
);
   logic                         clkEn;
   logic                         startFrame;
   logic                         startBlock;
   logic [DATA_W-1:0]            in0Real;
   logic [DATA_W-1:0]            in0Imag;
   logic                         setupValid;
   logic [DATA_W-1:0]            setupReal;
   logic [DATA_W-1:0]            setupImag;
   logic                         startStage;
   logic                         accMetricInEn;
   logic [METRIC_W-1:0]          accMetricIn;
   logic                         tableFull;
   logic                         setupErr;
   logic                         busy;
   logic                         startNextStage;
   logic                         metricOutEn;
   logic [$clog2(STATES)-1:0]    metricOutState;
   logic [LANES*METRIC_W-1:0]    accMetricOut;
   logic                         stageDone;
   logic [METRIC_W-1:0]          stageMin;

   modport master (
      output clkEn, startFrame, startBlock, in0Real, in0Imag, setupValid, setupReal, setupImag,
             startStage, accMetricInEn, accMetricIn,
      input  tableFull, setupErr, busy, startNextStage, metricOutEn, metricOutState, accMetricOut,
             stageDone, stageMin
   );

   modport slave (
      input  clkEn, startFrame, startBlock, in0Real, in0Imag, setupValid, setupReal, setupImag,
             startStage, accMetricInEn, accMetricIn,
      output tableFull, setupErr, busy, startNextStage, metricOutEn, metricOutState, accMetricOut,
             stageDone, stageMin
   );
endinterface

// File: rtl/acs_stage_param.sv
// acs_stage_param: parametrised add-compare-select metric stage with banked reference table
module acs_stage_param #(
   parameter int DATA_W   = 18,
   parameter int METRIC_W = 18,
   parameter int STATES   = 16,
   parameter int LANES    = 2,
   parameter int NORM_EN  = 0
) (
   input logic            clk,
   input logic            nReset,
   acs_stage_param_if.slave bus
);
   localparam int SW   = $clog2(STATES);
   localparam int LW   = LANES > 1 ? $clog2(LANES) : 1;
   localparam int SUMW = (METRIC_W > DATA_W + 2 ? METRIC_W : DATA_W + 2) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

   stateT                     state, nextState;
   logic                      abort, run, accept, lastAcc, finish, wrOk;
   logic [SW-1:0]             stateCnt, wrState, s1State, outState;
   logic [LW-1:0]             wrLane;
   logic [1:0]                drainCnt;
   logic [DATA_W-1:0]         tabR [LANES][STATES];
   logic [DATA_W-1:0]         tabI [LANES][STATES];
   logic [DATA_W-1:0]         s1R [LANES];
   logic [DATA_W-1:0]         s1I [LANES];
   logic [DATA_W-1:0]         yR, yI, s1YR, s1YI;
   logic [METRIC_W-1:0]       normOffset, s1M, runMin, outMin, stageMin;
   logic [METRIC_W-1:0]       sat [LANES];
   logic [LANES*METRIC_W-1:0] outReg;
   logic                      v1, outEn, tableFull, setupErr, startNext, stageDone;

   // Next-state and run-control decode; a frame abort overrides everything
   always_comb begin
      abort     = bus.clkEn & bus.startFrame;
      run       = !abort && state == IDLE && bus.startStage && tableFull;
      accept    = !abort && state == RUN && bus.accMetricInEn;
      lastAcc   = accept && stateCnt == SW'(STATES - 1);
      finish    = !abort && state == DRAIN && drainCnt == 2'd2;
      wrOk      = bus.setupValid && !abort && state == IDLE && !tableFull;
      nextState = abort ? IDLE : run ? RUN : lastAcc ? DRAIN : finish ? IDLE : state;
   end

   // FSM state register
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= nextState;
   end

   // Stage sequencing: state counter, drain timer, running minimum and offset
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         stateCnt   <= '0;
         drainCnt   <= '0;
         startNext  <= 1'b0;
         stageDone  <= 1'b0;
         stageMin   <= '0;
         normOffset <= '0;
         runMin     <= '1;
      end else begin
         startNext  <= run;
         stageDone  <= finish;
         stateCnt   <= run ? '0 : accept ? stateCnt + 1'b1 : stateCnt;
         drainCnt   <= state == DRAIN ? drainCnt + 1'b1 : '0;
         runMin     <= run ? '1 : outEn ? outMin : runMin;
         stageMin   <= finish ? runMin : stageMin;
         normOffset <= abort ? '0 : (finish && NORM_EN != 0) ? runMin : normOffset;
      end
   end

   // Sequential table write pointer, full flag and rejected-write pulse
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wrLane    <= '0;
         wrState   <= '0;
         tableFull <= 1'b0;
         setupErr  <= 1'b0;
      end else begin
         setupErr <= bus.setupValid && !abort && !wrOk;
         if (abort) begin
            wrLane    <= '0;
            wrState   <= '0;
            tableFull <= 1'b0;
         end else if (wrOk) begin
            wrLane <= wrLane == LW'(LANES - 1) ? '0 : wrLane + 1'b1;
            if (wrLane == LW'(LANES - 1)) begin
               wrState   <= wrState + 1'b1;
               tableFull <= wrState == SW'(STATES - 1);
            end
         end
      end
   end

   // Reference table, one bank per lane so a state reads all lanes at once
   always_ff @(posedge clk) begin
      if (wrOk) begin
         tabR[wrLane][wrState] <= bus.setupReal;
         tabI[wrLane][wrState] <= bus.setupImag;
      end
      for (int i = 0; i < LANES; i++) begin
         s1R[i] <= tabR[i][stateCnt];
         s1I[i] <= tabI[i][stateCnt];
      end
   end

   // Block sample latch
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         yR <= '0;
         yI <= '0;
      end else if (bus.clkEn && bus.startBlock) begin
         yR <= bus.in0Real;
         yI <= bus.in0Imag;
      end
   end

   // Pipeline stage 1: normalised input metric and the sample it is paired with
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         v1      <= 1'b0;
         s1State <= '0;
         s1M     <= '0;
         s1YR    <= '0;
         s1YI    <= '0;
      end else begin
         v1 <= accept;
         if (accept) begin
            s1State <= stateCnt;
            s1M     <= bus.accMetricIn >= normOffset ? bus.accMetricIn - normOffset : '0;
            s1YR    <= yR;
            s1YI    <= yI;
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : gLane
      logic [DATA_W:0]   dR, dI, aR, aI;
      logic [DATA_W+1:0] bm;
      logic [SUMW-1:0]   sum;
      assign dR     = {s1R[l][DATA_W-1], s1R[l]} - {s1YR[DATA_W-1], s1YR};
      assign dI     = {s1I[l][DATA_W-1], s1I[l]} - {s1YI[DATA_W-1], s1YI};
      assign aR     = dR[DATA_W] ? -dR : dR;
      assign aI     = dI[DATA_W] ? -dI : dI;
      assign bm     = {1'b0, aR} + {1'b0, aI};
      assign sum    = SUMW'(s1M) + SUMW'(bm);
      assign sat[l] = |sum[SUMW-1:METRIC_W] ? '1 : sum[METRIC_W-1:0];
   end

   // Pipeline stage 2: saturated lane sums; an abort drops the in-flight entry
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         outEn    <= 1'b0;
         outState <= '0;
         outReg   <= '0;
      end else begin
         outEn <= v1 && !abort;
         if (v1) begin
            outState <= s1State;
            for (int i = 0; i < LANES; i++) outReg[i*METRIC_W +: METRIC_W] <= sat[i];
         end
      end
   end

   // Running minimum folded with the lanes currently on the output
   always_comb begin
      outMin = runMin;
      for (int i = 0; i < LANES; i++)
         outMin = outReg[i*METRIC_W +: METRIC_W] < outMin ? outReg[i*METRIC_W +: METRIC_W] : outMin;
   end

   assign bus.tableFull      = tableFull;
   assign bus.setupErr       = setupErr;
   assign bus.busy           = state != IDLE;
   assign bus.startNextStage = startNext;
   assign bus.metricOutEn    = outEn;
   assign bus.metricOutState = outState;
   assign bus.accMetricOut   = outReg;
   assign bus.stageDone      = stageDone;
   assign bus.stageMin       = stageMin;
endmodule

// File: tb/tb_acs_stage_param.sv
// tb_acs_stage_param: directed bench driving a plain and a normalising ACS stage in parallel
module tb_acs_stage_param;
   logic clk, nReset;
   int   cyc = 0, nCmp = 0, nErr = 0, doneCnt = 0, doneCyc = -1, nsCnt = 0;
   int   y = 0;
   bit   satTab = 0;
   int   mv [16];

   typedef struct {
      int          due;
      int          st;
      logic [35:0] o0;
      logic [35:0] o1;
   } expT;
   expT q[$];
   expT e;

   acs_stage_param_if b0 ();
   acs_stage_param_if b1 ();

   assign b1.clkEn         = b0.clkEn;
   assign b1.startFrame    = b0.startFrame;
   assign b1.startBlock    = b0.startBlock;
   assign b1.in0Real       = b0.in0Real;
   assign b1.in0Imag       = b0.in0Imag;
   assign b1.setupValid    = b0.setupValid;
   assign b1.setupReal     = b0.setupReal;
   assign b1.setupImag     = b0.setupImag;
   assign b1.startStage    = b0.startStage;
   assign b1.accMetricInEn = b0.accMetricInEn;
   assign b1.accMetricIn   = b0.accMetricIn;

   acs_stage_param #(.NORM_EN(0)) dut0 (.clk(clk), .nReset(nReset), .bus(b0.slave));
   acs_stage_param #(.NORM_EN(1)) dut1 (.clk(clk), .nReset(nReset), .bus(b1.slave));

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] expv(input int m, input int off, input int s);
      logic [35:0] r;
      int mm, k, v;
      mm = m > off ? m - off : 0;
      for (int l = 0; l < 2; l++) begin
         k = 2 * s + l;
         k = (satTab && k == 0) ? -10 : k;
         v = mm + (k > y ? k - y : y - k);
         v = v > 262143 ? 262143 : v;
         r[l*18 +: 18] = 18'(v);
      end
      return r;
   endfunction

   // Output scoreboard plus pulse counters
   always @(negedge clk) begin
      if (b0.stageDone) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (b0.startNextStage) nsCnt++;
      if (nReset && (b0.metricOutEn || b1.metricOutEn)) begin
         if (q.size() == 0) check("unexpectedOut", 1, 0);
         else begin
            e = q.pop_front();
            check("outCycle", cyc, e.due);
            check("outEn1", b1.metricOutEn, 1);
            check("outState", b0.metricOutState, e.st);
            check("out0", b0.accMetricOut, e.o0);
            check("out1", b1.accMetricOut, e.o1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int r, input int i);
      b0.setupValid = 1;
      b0.setupReal  = 18'(r);
      b0.setupImag  = 18'(i);
      tick();
      b0.setupValid = 0;
   endtask

   task automatic startStg();
      b0.startStage = 1;
      tick();
      b0.startStage = 0;
   endtask

   task automatic blk(input int r);
      b0.clkEn = 1; b0.startBlock = 1;
      b0.in0Real = 18'(r); b0.in0Imag = '0;
      tick();
      b0.clkEn = 0; b0.startBlock = 0;
      y = r;
   endtask

   task automatic abortFrame();
      b0.clkEn = 1; b0.startFrame = 1;
      tick();
      b0.clkEn = 0; b0.startFrame = 0;
   endtask

   task automatic loadTable();
      for (int k = 0; k < 32; k++) wr((satTab && k == 0) ? -10 : k, 0);
   endtask

   task automatic feed(input int s, input int off1, input bit push);
      b0.accMetricInEn = 1;
      b0.accMetricIn   = 18'(mv[s]);
      if (push) q.push_back('{cyc + 2, s, expv(mv[s], 0, s), expv(mv[s], off1, s)});
      tick();
      b0.accMetricInEn = 0;
   endtask

   task automatic runStage(input bit probe, input int off1, input int min0, input int min1);
      int d0, n0, last;
      d0 = doneCnt;
      n0 = nsCnt;
      startStg();
      @(negedge clk);
      check("startNextStage", b0.startNextStage, 1);
      check("busyRun", b0.busy, 1);
      tick();
      if (probe) begin
         wr(7, 7);
         @(negedge clk);
         check("setupErrInRun", b0.setupErr, 1);
         tick();
         startStg();
      end
      for (int s = 0; s < 16; s++) feed(s, off1, 1);
      last = cyc - 1;
      repeat (8) tick();
      check("doneCycle", doneCyc, last + 4);
      check("donePulses", doneCnt - d0, 1);
      check("nextStagePulses", nsCnt - n0, 1);
      check("stageMin0", b0.stageMin, min0);
      check("stageMin1", b1.stageMin, min1);
      check("busyAfter", b0.busy, 0);
      check("outsPending", q.size(), 0);
   endtask

   initial begin
      int d0;
      nReset = 0;
      b0.clkEn = 0; b0.startFrame = 0; b0.startBlock = 0;
      b0.in0Real = '0; b0.in0Imag = '0;
      b0.setupValid = 0; b0.setupReal = '0; b0.setupImag = '0;
      b0.startStage = 0; b0.accMetricInEn = 0; b0.accMetricIn = '0;
      for (int s = 0; s < 16; s++) mv[s] = 100;
      repeat (3) tick();
      check("rstBusy", b0.busy, 0);
      check("rstFull", b0.tableFull, 0);
      check("rstOutEn", b0.metricOutEn, 0);
      check("rstStageMin", b0.stageMin, 0);
      nReset = 1;
      tick();

      for (int k = 0; k < 31; k++) wr(k, 0);
      startStg();
      check("busyNotFull", b0.busy, 0);
      check("fullAfter31", b0.tableFull, 0);
      wr(31, 0);
      @(negedge clk);
      check("fullAfter32", b0.tableFull, 1);
      tick();
      wr(999, 999);
      @(negedge clk);
      check("setupErr33", b0.setupErr, 1);
      tick();
      check("setupErrPulse", b0.setupErr, 0);

      blk(0);
      runStage(1, 0, 100, 100);

      blk(5);
      for (int s = 0; s < 16; s++) mv[s] = 200;
      mv[0] = 150;
      mv[5] = 80;
      runStage(0, 100, 85, 5);

      blk(0);
      for (int s = 0; s < 16; s++) mv[s] = 100;
      d0 = doneCnt;
      startStg();
      for (int s = 0; s < 4; s++) feed(s, 5, 1);
      feed(4, 5, 0);
      b0.accMetricInEn = 1; b0.accMetricIn = 18'(100);
      abortFrame();
      b0.accMetricInEn = 0;
      @(negedge clk);
      check("abortBusy", b0.busy, 0);
      check("abortFull", b0.tableFull, 0);
      repeat (8) tick();
      check("abortNoDone", doneCnt - d0, 0);
      check("abortPending", q.size(), 0);

      loadTable();
      blk(0);
      runStage(0, 0, 100, 100);

      abortFrame();
      satTab = 1;
      loadTable();
      blk(10);
      for (int s = 0; s < 16; s++) mv[s] = 262140;
      runStage(0, 0, 262140, 262140);

      startStg();
      feed(0, 0, 0);
      feed(1, 0, 0);
      check("preRstOutEn", b0.metricOutEn, 1);
      nReset = 0;
      #1;
      check("asyncOutEn", b0.metricOutEn, 0);
      check("asyncOut", b0.accMetricOut, 0);
      check("asyncBusy", b0.busy, 0);
      check("asyncFull", b0.tableFull, 0);
      check("asyncMin", b0.stageMin, 0);
      check("asyncOutEn1", b1.metricOutEn, 0);
      repeat (2) tick();
      nReset = 1;
      tick();
      check("postRstBusy", b0.busy, 0);
      check("postRstFull", b0.tableFull, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
